branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
- Parametrised branch resolution and prediction unit for the pipelined RV32I core.
- Resolves all six conditional branches plus JAL/JALR in EX and trains a direct-mapped table of 2-bit saturating counters (BHT) indexed by PC.
- Supplies a taken prediction to IF, redirect source selection to the PC mux, and a multi-cycle flush to the pipeline registers on misprediction.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_DEPTH, 16, number of counters; power of two, at least 2.
- FLUSH_CYCLES, 2, cycles flush_o stays asserted per misprediction; at least 1.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- if_valid_i  in  1  fetch slot holds a real instruction.
- if_pc_i  in  XLEN  fetch PC.
- if_pred_taken_o  out  1  BHT prediction for if_pc_i.
- ex_valid_i  in  1  EX slot holds a real instruction.
- ex_op_i  in  7  opcode.
- ex_funct3_i  in  3  funct3.
- ex_pc_i  in  XLEN  PC of the EX instruction.
- ex_a_i, ex_b_i  in  XLEN each  rs1 and rs2 values.
- ex_pred_taken_i  in  1  prediction carried down the pipe with the instruction.
- ex_taken_o  out  1  resolved outcome.
- mispredict_o  out  1  redirect required this cycle.
- redirect_sel_o  out  2  00 = PC+imm, 01 = rs1+imm (JALR), 10 = PC+4, 11 unused.
- flush_o  out  1  squash the IF/ID and ID/EX registers.
- stat_branches_o, stat_mispred_o  out  32 each  statistics (see Optional Feature).

Behaviour:
- Reset (reset low, asynchronous):
  - All BHT entries load 2'b01 (weakly not-taken).
  - Flush counter clears to 0; the unit enters IDLE.
  - All outputs are 0. if_pred_taken_o reads 0 because bit 1 of every entry is 0.
  - Reset asserted during FLUSH aborts the flush immediately.
- Opcodes:
  - BRANCH 1100011 with funct3 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
  - JALR 1100111 with funct3 000.
  - JAL 1101111, any funct3.
  - Anything else, including branch funct3 010 and 011, is not control flow: ex_taken_o = 0 and there is no BHT update.
- Compare rules:
  - blt and bge use a signed XLEN compare; bltu and bgeu use an unsigned compare.
  - Compares are direct comparisons, not sign-of-difference. Example: blt 0x80000000 < 0x7FFFFFFF is taken.
- Effective valid: eff_valid = ex_valid_i and state == IDLE. An instruction in EX during FLUSH is a squashed shadow and is ignored.
- Resolution (combinational, zero latency, gated by eff_valid):
  - Conditional branch: ex_taken_o = compare result; mispredict_o = ex_taken_o XOR ex_pred_taken_i.
    - On mispredict with taken = 1, redirect_sel_o = 00; with taken = 0, redirect_sel_o = 10.
  - JAL: ex_taken_o = 1; mispredict_o = not ex_pred_taken_i; redirect_sel_o = 00.
  - JALR: ex_taken_o = 1; mispredict_o = 1 always; redirect_sel_o = 01.
  - redirect_sel_o is 00 whenever mispredict_o = 0.
- Prediction:
  - Index = if_pc_i[log2(BHT_DEPTH)+1 : 2].
  - if_pred_taken_o = if_valid_i and entry[index][1].
  - Combinational read.
- Training (clocked):
  - On eff_valid and a conditional branch, entry[ex index] increments if taken, decrements if not.
  - Counters saturate at 11 and 00.
  - JAL and JALR never train.
  - Same-cycle read and write to one index: the read returns the pre-update value (no bypass).
- Flush FSM:
  - IDLE: on mispredict_o, load cnt = FLUSH_CYCLES-1; go to FLUSH if cnt != 0, otherwise stay in IDLE.
  - FLUSH: cnt decrements each cycle; return to IDLE when it reaches 0.
  - flush_o = mispredict_o or (state == FLUSH). Total flush length is exactly FLUSH_CYCLES cycles.
  - A mispredict cannot occur in FLUSH because eff_valid = 0 there.
- Index aliasing between different PCs is permitted and is not detected.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - stat_branches_o counts eff_valid control-flow instructions (conditional, JAL, JALR).
  - stat_mispred_o counts cycles with mispredict_o = 1.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Not defined: both ports are tied to 0 and no counter flops are synthesised.

Decomposition:
- Package branch_pkg:
  - opcode constants BRANCH, JAL, JALR;
  - funct3 constants for the six branches;
  - redirect_sel encodings;
  - 2-bit counter encodings: SNT 00, WNT 01, WT 10, ST 11;
  - FSM state enum IDLE/FLUSH.
- Sub-module branch_bht holds the counter array:
  - one combinational read port, one saturating update port;
  - reset initialisation;
  - parameter BHT_DEPTH.
- The top level holds compare, resolve, flush FSM and stats.

Test Plan:
- Reset, then if_valid_i = 1 with any PC -> if_pred_taken_o = 0; every output 0.
- bne, A=5, B=5, pred=1 at PC 0x40 -> taken 0, mispredict 1, redirect_sel 10, flush_o high 2 cycles. The instruction presented in EX during the second cycle is ignored.
- bltu A=0xFFFFFFFF, B=1 -> not taken. blt with the same operands -> taken.
- Three taken beq at PC 0x40 with pred=0 -> entry[0] goes 01→10→11→11 (saturates). if_pc_i = 0x40 then predicts 1, and the alias PC 0x80 also predicts 1.
- JALR with pred=1 -> mispredict 1, redirect_sel 01, no BHT change. JAL with pred=1 -> mispredict 0, no flush.
- Reset pulsed during the FLUSH cycle -> flush_o drops asynchronously and the BHT is back to 01. With BRANCH_STATS_EN, stat counters read 0 after reset and increment 1/1 per mispredicted branch.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolution / prediction unit: opcodes,
// funct3 values, redirect-source selects, 2-bit counter states and flush FSM states.
package branch_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] SEL_PC_IMM  = 2'b00;
    localparam logic [1:0] SEL_RS1_IMM = 2'b01;
    localparam logic [1:0] SEL_PC_4    = 2'b10;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef enum logic {
        IDLE,
        FLUSH
    } flush_state_e;

endpackage

// File: rtl/branch_bht.sv
// Direct-mapped table of 2-bit saturating counters with one combinational
// read port and one clocked update port; entries reset to weakly not-taken.
module branch_bht
    import branch_pkg::*;
#(
    parameter int BHT_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(BHT_DEPTH)-1:0] rd_idx,
    output logic [1:0]                   rd_ctr,
    input  logic                         wr_en,
    input  logic [$clog2(BHT_DEPTH)-1:0] wr_idx,
    input  logic                         wr_taken
);

    logic [1:0] ctr_q [BHT_DEPTH];

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == CTR_ST) ? CTR_ST : v + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] v);
        return (v == CTR_SNT) ? CTR_SNT : v - 2'd1;
    endfunction

    // Reads see the pre-update value when the same index is written this cycle.
    assign rd_ctr = ctr_q[rd_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (wr_en) begin
            ctr_q[wr_idx] <= wr_taken ? sat_inc(ctr_q[wr_idx]) : sat_dec(ctr_q[wr_idx]);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution, BHT prediction/training and multi-cycle flush control.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_DEPTH    = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            if_pred_taken_o,
    input  logic            ex_valid_i,
    input  logic [6:0]      ex_op_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ex_a_i,
    input  logic [XLEN-1:0] ex_b_i,
    input  logic            ex_pred_taken_i,
    output logic            ex_taken_o,
    output logic            mispredict_o,
    output logic [1:0]      redirect_sel_o,
    output logic            flush_o,
    output logic [31:0]     stat_branches_o,
    output logic [31:0]     stat_mispred_o
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    flush_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             eff_valid;
    logic             is_cond, is_jal, is_jalr;
    logic             cmp_taken;
    logic [1:0]       rd_ctr;

    logic signed [XLEN-1:0] a_s, b_s;

    logic unused_pc;
    assign unused_pc = ^{if_pc_i[XLEN-1:IDX_W+2], if_pc_i[1:0],
                         ex_pc_i[XLEN-1:IDX_W+2], ex_pc_i[1:0], rd_ctr[0]};

    assign a_s = ex_a_i;
    assign b_s = ex_b_i;

    // Shadow instructions arriving while the pipe is being squashed are ignored.
    assign eff_valid = ex_valid_i && (state_q == IDLE);

    always_comb begin
        is_cond   = 1'b0;
        cmp_taken = 1'b0;
        if (ex_op_i == OP_BRANCH) begin
            is_cond = 1'b1;
            case (ex_funct3_i)
                F3_BEQ:  cmp_taken = (ex_a_i == ex_b_i);
                F3_BNE:  cmp_taken = (ex_a_i != ex_b_i);
                F3_BLT:  cmp_taken = (a_s < b_s);
                F3_BGE:  cmp_taken = (a_s >= b_s);
                F3_BLTU: cmp_taken = (ex_a_i < ex_b_i);
                F3_BGEU: cmp_taken = (ex_a_i >= ex_b_i);
                default: is_cond   = 1'b0;
            endcase
        end
    end

    assign is_jal  = (ex_op_i == OP_JAL);
    assign is_jalr = (ex_op_i == OP_JALR) && (ex_funct3_i == 3'b000);

    always_comb begin
        ex_taken_o     = 1'b0;
        mispredict_o   = 1'b0;
        redirect_sel_o = SEL_PC_IMM;
        if (eff_valid) begin
            if (is_cond) begin
                ex_taken_o   = cmp_taken;
                mispredict_o = cmp_taken ^ ex_pred_taken_i;
                if (mispredict_o && !cmp_taken) begin
                    redirect_sel_o = SEL_PC_4;
                end
            end else if (is_jal) begin
                ex_taken_o   = 1'b1;
                mispredict_o = !ex_pred_taken_i;
            end else if (is_jalr) begin
                ex_taken_o     = 1'b1;
                mispredict_o   = 1'b1;
                redirect_sel_o = SEL_RS1_IMM;
            end
        end
    end

    branch_bht #(
        .BHT_DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (if_pc_i[IDX_W+1:2]),
        .rd_ctr   (rd_ctr),
        .wr_en    (eff_valid && is_cond),
        .wr_idx   (ex_pc_i[IDX_W+1:2]),
        .wr_taken (cmp_taken)
    );

    assign if_pred_taken_o = if_valid_i && rd_ctr[1];

    // The mispredict cycle itself is the first flush cycle; FLUSH covers the rest.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mispredict_o) begin
                    cnt_d = CNT_LOAD;
                    if (CNT_LOAD != '0) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign flush_o = mispredict_o || (state_q == FLUSH);

`ifdef BRANCH_STATS_EN
    logic [31:0] branches_q, mispred_q;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branches_q <= '0;
            mispred_q  <= '0;
        end else begin
            if (eff_valid && (is_cond || is_jal || is_jalr)) begin
                branches_q <= sat_inc32(branches_q);
            end
            if (mispredict_o) begin
                mispred_q <= sat_inc32(mispred_q);
            end
        end
    end

    assign stat_branches_o = branches_q;
    assign stat_mispred_o  = mispred_q;
`else
    assign stat_branches_o = '0;
    assign stat_mispred_o  = '0;
`endif

endmodule
